// File: rtl/dcf77_sync_ctrl.sv
// dcf77_sync_ctrl: DCF77 frame plausibility/lock controller with sync strobe; optional statistics via DCF77_SYNC_STATS_EN
module dcf77_sync_ctrl #(
  parameter int REQUIRED_MATCHES = 2,
  parameter int HOLDOVER_MIN = 60,
  parameter int FRAME_TIMEOUT = 6100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_en,
  input  logic       frame_valid,
  input  logic [7:0] frame_year,
  input  logic [7:0] frame_month,
  input  logic [7:0] frame_day,
  input  logic [7:0] frame_hour,
  input  logic [7:0] frame_minute,
  input  logic [2:0] frame_day_of_week,
  output logic       dcf77_sync,
  output logic [7:0] sync_year,
  output logic [7:0] sync_month,
  output logic [7:0] sync_day,
  output logic [7:0] sync_hour,
  output logic [7:0] sync_minute,
  output logic [2:0] sync_day_of_week,
  output logic       locked,
  output logic       holdover,
  output logic [15:0] good_frames,
  output logic [15:0] rejected_frames
);
  typedef enum logic [1:0] {UNLOCKED, CANDIDATE, LOCKED, HOLDOVER} state_t;
  typedef struct packed {
    logic [7:0] year;
    logic [7:0] month;
    logic [7:0] day;
    logic [2:0] dow;
    logic [7:0] hour;
    logic [7:0] minute;
  } stamp_t;
  localparam stamp_t RESET_STAMP = '{year: 8'h00, month: 8'h01, day: 8'h01, dow: 3'd1, hour: 8'h00, minute: 8'h00};
  localparam logic [2:0] MATCH_LIM = 3'(REQUIRED_MATCHES);
  localparam logic [7:0] MISS_LIM = 8'(HOLDOVER_MIN);
  localparam logic [12:0] TICK_LAST = 13'(FRAME_TIMEOUT - 1);
  localparam logic [12:0] TICK_RELOAD = 13'(FRAME_TIMEOUT - 6000);

  state_t state_q, state_d;
  stamp_t frame, ref_q, ref_d, sync_q, sync_d;
  logic [12:0] tick_q, tick_d;
  logic [2:0] match_q, match_d, match_inc;
  logic [7:0] miss_q, miss_d, miss_inc;
  logic dcf77_sync_q, dcf77_sync_d, locked_q, locked_d, holdover_q, holdover_d;
  logic timeout, issue, plausible, min_wrap, midnight;
  logic [7:0] exp_minute, exp_hour;

  assign frame = {frame_year, frame_month, frame_day, frame_day_of_week, frame_hour, frame_minute};
  assign timeout = clk_en && !frame_valid && tick_q == TICK_LAST;
  assign tick_d = frame_valid ? '0 : timeout ? TICK_RELOAD : clk_en ? tick_q + 13'd1 : tick_q;
  assign match_inc = match_q + 3'd1;
  assign miss_inc = miss_q + 8'd1;
  assign min_wrap = ref_q.minute == 8'h59;
  assign midnight = min_wrap && ref_q.hour == 8'h23;
  assign exp_minute = min_wrap ? 8'h00 :
                      ref_q.minute[3:0] == 4'd9 ? {ref_q.minute[7:4] + 4'd1, 4'd0} :
                      {ref_q.minute[7:4], ref_q.minute[3:0] + 4'd1};
  assign exp_hour = !min_wrap ? ref_q.hour : ref_q.hour == 8'h23 ? 8'h00 :
                    ref_q.hour[3:0] == 4'd9 ? {ref_q.hour[7:4] + 4'd1, 4'd0} :
                    {ref_q.hour[7:4], ref_q.hour[3:0] + 4'd1};
  assign plausible = frame.minute == exp_minute && frame.hour == exp_hour &&
                     (midnight || (frame.year == ref_q.year && frame.month == ref_q.month &&
                                   frame.day == ref_q.day && frame.dow == ref_q.dow));

  // lock state machine: candidate counting, lock, holdover and reference tracking
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    miss_d = miss_q;
    ref_d = ref_q;
    issue = 1'b0;
    case (state_q)
      UNLOCKED: if (frame_valid) begin
        ref_d = frame;
        match_d = 3'd1;
        state_d = CANDIDATE;
      end
      CANDIDATE: if (frame_valid) begin
        ref_d = frame;
        match_d = plausible ? match_inc : 3'd1;
        if (plausible && match_inc == MATCH_LIM) begin
          state_d = LOCKED;
          miss_d = '0;
          issue = 1'b1;
        end
      end else if (timeout) state_d = UNLOCKED;
      default: if (frame_valid && plausible) begin
        ref_d = frame;
        miss_d = '0;
        state_d = LOCKED;
        issue = 1'b1;
      end else if (frame_valid || timeout) begin
        ref_d.hour = exp_hour;
        ref_d.minute = exp_minute;
        miss_d = miss_inc;
        state_d = miss_inc == MISS_LIM ? UNLOCKED : HOLDOVER;
      end
    endcase
  end

  // sync capture and strobe that lasts through the next clk_en cycle
  always_comb begin
    sync_d = issue ? frame : sync_q;
    dcf77_sync_d = issue ? 1'b1 : dcf77_sync_q && !clk_en;
    locked_d = state_d == LOCKED || state_d == HOLDOVER;
    holdover_d = state_d == HOLDOVER;
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= UNLOCKED;
      tick_q <= '0;
      match_q <= '0;
      miss_q <= '0;
      ref_q <= RESET_STAMP;
      sync_q <= RESET_STAMP;
      dcf77_sync_q <= 1'b0;
      locked_q <= 1'b0;
      holdover_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      match_q <= match_d;
      miss_q <= miss_d;
      ref_q <= ref_d;
      sync_q <= sync_d;
      dcf77_sync_q <= dcf77_sync_d;
      locked_q <= locked_d;
      holdover_q <= holdover_d;
    end
  end

  assign {sync_year, sync_month, sync_day, sync_day_of_week, sync_hour, sync_minute} = sync_q;
  assign dcf77_sync = dcf77_sync_q;
  assign locked = locked_q;
  assign holdover = holdover_q;

`ifdef DCF77_SYNC_STATS_EN
  logic [15:0] good_q, good_d, rej_q, rej_d;
  logic judged;
  assign judged = frame_valid && state_q != UNLOCKED;
  // saturating counts of frames judged against the reference
  always_comb begin
    good_d = good_q + {15'd0, judged && plausible && good_q != 16'hFFFF};
    rej_d = rej_q + {15'd0, judged && !plausible && rej_q != 16'hFFFF};
  end
  // statistics registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      good_q <= '0;
      rej_q <= '0;
    end else begin
      good_q <= good_d;
      rej_q <= rej_d;
    end
  end
  assign good_frames = good_q;
  assign rejected_frames = rej_q;
`else
  assign good_frames = '0;
  assign rejected_frames = '0;
`endif
endmodule

// File: tb/tb_dcf77_sync_ctrl.sv
// tb_dcf77_sync_ctrl: self-checking bench with a minute-of-day reference model
module tb_dcf77_sync_ctrl;
  localparam int RM = 2;
  localparam int HM = 3;
  localparam int FT = 6100;

  typedef struct {int mod; int y; int mo; int d; int w;} frm_t;

  logic clk = 1'b0, reset_n = 1'b0, clk_en = 1'b0, frame_valid = 1'b0;
  logic [7:0] frame_year = '0, frame_month = '0, frame_day = '0, frame_hour = '0, frame_minute = '0;
  logic [2:0] frame_day_of_week = 3'd1;
  logic dcf77_sync, locked, holdover;
  logic [7:0] sync_year, sync_month, sync_day, sync_hour, sync_minute;
  logic [2:0] sync_day_of_week;
  logic [15:0] good_frames, rejected_frames;
  logic [77:0] act;

  bit m_locked, m_hold, m_pend;
  int m_matches, m_misses, m_ticks, m_good, m_bad;
  frm_t m_ref, m_sync, z;
  int vectors = 0, miscompares = 0, hi_cnt = 0, q_cnt = 0;

  always #5 clk = ~clk;

  dcf77_sync_ctrl #(.REQUIRED_MATCHES(RM), .HOLDOVER_MIN(HM), .FRAME_TIMEOUT(FT)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .frame_valid(frame_valid),
    .frame_year(frame_year), .frame_month(frame_month), .frame_day(frame_day),
    .frame_hour(frame_hour), .frame_minute(frame_minute), .frame_day_of_week(frame_day_of_week),
    .dcf77_sync(dcf77_sync), .sync_year(sync_year), .sync_month(sync_month), .sync_day(sync_day),
    .sync_hour(sync_hour), .sync_minute(sync_minute), .sync_day_of_week(sync_day_of_week),
    .locked(locked), .holdover(holdover), .good_frames(good_frames), .rejected_frames(rejected_frames)
  );

  assign act = {dcf77_sync, locked, holdover, sync_year, sync_month, sync_day, sync_day_of_week,
                sync_hour, sync_minute, good_frames, rejected_frames};

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic frm_t mk(input int h, input int mi, input int y, input int mo, input int d, input int w);
    frm_t f;
    f.mod = h * 60 + mi; f.y = y; f.mo = mo; f.d = d; f.w = w;
    return f;
  endfunction

  function automatic frm_t rnd_frame();
    return mk($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 99),
              $urandom_range(1, 12), $urandom_range(1, 28), $urandom_range(1, 7));
  endfunction

  function automatic logic [77:0] exp_out();
    logic [15:0] g, r;
`ifdef DCF77_SYNC_STATS_EN
    g = 16'(m_good); r = 16'(m_bad);
`else
    g = '0; r = '0;
`endif
    return {m_pend, m_locked, m_hold, bcd(m_sync.y), bcd(m_sync.mo), bcd(m_sync.d), 3'(m_sync.w),
            bcd(m_sync.mod / 60), bcd(m_sync.mod % 60), g, r};
  endfunction

  function automatic int exp_rej(input int n);
`ifdef DCF77_SYNC_STATS_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_locked = 0; m_hold = 0; m_pend = 0;
    m_matches = 0; m_misses = 0; m_ticks = 0; m_good = 0; m_bad = 0;
    m_ref = mk(0, 0, 0, 1, 1, 1);
    m_sync = m_ref;
  endtask

  task automatic model_step(input bit en, input bit fv, input frm_t f);
    bit timeout, plaus, issue;
    timeout = 0; issue = 0;
    if (fv) m_ticks = 0;
    else if (en) begin
      m_ticks++;
      if (m_ticks == FT) begin timeout = 1; m_ticks = FT - 6000; end
    end
    plaus = f.mod == (m_ref.mod + 1) % 1440 &&
            (m_ref.mod == 1439 || (f.y == m_ref.y && f.mo == m_ref.mo && f.d == m_ref.d && f.w == m_ref.w));
    if (fv && !m_locked && m_matches == 0) begin
      m_ref = f; m_matches = 1;
    end else if (fv && !m_locked) begin
      if (plaus) m_good++; else m_bad++;
      m_ref = f;
      m_matches = plaus ? m_matches + 1 : 1;
      if (m_matches == RM) begin m_locked = 1; m_hold = 0; m_misses = 0; issue = 1; end
    end else if (fv && plaus) begin
      m_good++; m_ref = f; m_misses = 0; m_hold = 0; issue = 1;
    end else if (fv || (timeout && m_locked)) begin
      if (fv) m_bad++;
      m_ref.mod = (m_ref.mod + 1) % 1440;
      m_misses++; m_hold = 1;
      if (m_misses >= HM) begin m_locked = 0; m_hold = 0; m_matches = 0; end
    end else if (timeout) m_matches = 0;
    if (issue) begin m_sync = f; m_pend = 1; end
    else if (m_pend && en) m_pend = 0;
  endtask

  task automatic tick(input bit en, input bit fv, input frm_t f);
    clk_en = en; frame_valid = fv;
    frame_year = bcd(f.y); frame_month = bcd(f.mo); frame_day = bcd(f.d);
    frame_hour = bcd(f.mod / 60); frame_minute = bcd(f.mod % 60); frame_day_of_week = 3'(f.w);
    if (dcf77_sync) hi_cnt++;
    if (dcf77_sync && en) q_cnt++;
    @(posedge clk);
    model_step(en, fv, f);
    @(negedge clk);
    clk_en = 1'b0; frame_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; clk_en = 1'b1; frame_valid = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1; clk_en = 1'b0; frame_valid = 1'b0;
  endtask

  task automatic lock_at(input frm_t f2);
    frm_t f1;
    f1 = f2;
    f1.mod = f2.mod - 1;
    tick(1, 1, f1);
    repeat (3) tick(1, 0, z);
    tick(1, 1, f2);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({dcf77_sync, locked, holdover} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 000", {dcf77_sync, locked, holdover});
    end
    vectors++;
    if ({sync_year, sync_month, sync_day, sync_day_of_week, sync_hour, sync_minute} !== 43'h00_01_01_1_00_00 &&
        {sync_year, sync_month, sync_day, sync_day_of_week, sync_hour, sync_minute} !== {8'h00, 8'h01, 8'h01, 3'd1, 8'h00, 8'h00}) begin
      miscompares++; $display("FAIL reset_sync: got %h", {sync_year, sync_month, sync_day, sync_day_of_week, sync_hour, sync_minute});
    end
    vectors++;
    if ({good_frames, rejected_frames} !== 32'h0) begin
      miscompares++; $display("FAIL reset_stats: got %h expected 0", {good_frames, rejected_frames});
    end
    vectors++;
    if (act !== exp_out()) begin
      miscompares++; $display("FAIL reset_model: got %h expected %h", act, exp_out());
    end
  endtask

  task automatic test_lock();
    frm_t f;
    do_reset();
    f = mk(12, 0, 24, 6, 15, 6);
    tick(1, 1, f);
    repeat (5999) tick(1, 0, z);
    f.mod++;
    hi_cnt = 0; q_cnt = 0;
    tick(1, 1, f);
    vectors++;
    if ({locked, dcf77_sync, sync_minute, sync_hour} !== {2'b11, 8'h01, 8'h12}) begin
      miscompares++; $display("FAIL lock_after_second: got %h expected 30112", {locked, dcf77_sync, sync_minute, sync_hour});
    end
    tick(0, 0, z); tick(0, 0, z); tick(1, 0, z); tick(0, 0, z); tick(1, 0, z);
    vectors++;
    if (hi_cnt != 3 || q_cnt != 1 || dcf77_sync !== 1'b0) begin
      miscompares++; $display("FAIL lock_strobe: got high=%0d qual=%0d sync=%b expected 3 1 0", hi_cnt, q_cnt, dcf77_sync);
    end
    vectors++;
    if (act !== exp_out()) begin
      miscompares++; $display("FAIL lock_model: got %h expected %h", act, exp_out());
    end
  endtask

  task automatic test_midnight();
    do_reset();
    lock_at(mk(23, 59, 24, 12, 31, 2));
    repeat (3) tick(1, 0, z);
    tick(1, 1, mk(0, 0, 25, 1, 1, 3));
    vectors++;
    if ({dcf77_sync, locked, holdover, sync_year, sync_month, sync_day, sync_hour, sync_minute} !== {3'b110, 8'h25, 8'h01, 8'h01, 8'h00, 8'h00}) begin
      miscompares++; $display("FAIL midnight: got %h expected %h", {dcf77_sync, locked, holdover, sync_year, sync_month, sync_day, sync_hour, sync_minute},
                              {3'b110, 8'h25, 8'h01, 8'h01, 8'h00, 8'h00});
    end
    vectors++;
    if (act !== exp_out()) begin
      miscompares++; $display("FAIL midnight_model: got %h expected %h", act, exp_out());
    end
  endtask

  task automatic test_reject();
    do_reset();
    lock_at(mk(12, 1, 24, 3, 10, 7));
    repeat (3) tick(1, 0, z);
    tick(1, 1, mk(12, 5, 24, 3, 10, 7));
    vectors++;
    if ({dcf77_sync, locked, holdover} !== 3'b011 || int'(rejected_frames) != exp_rej(1)) begin
      miscompares++; $display("FAIL reject: got flags=%b rej=%0d expected 011 %0d", {dcf77_sync, locked, holdover}, rejected_frames, exp_rej(1));
    end
    repeat (2) tick(1, 0, z);
    tick(1, 1, mk(12, 3, 24, 3, 10, 7));
    vectors++;
    if ({dcf77_sync, locked, holdover, sync_minute} !== {3'b110, 8'h03}) begin
      miscompares++; $display("FAIL relock: got %h expected %h", {dcf77_sync, locked, holdover, sync_minute}, {3'b110, 8'h03});
    end
    vectors++;
    if (act !== exp_out()) begin
      miscompares++; $display("FAIL reject_model: got %h expected %h", act, exp_out());
    end
  endtask

  task automatic test_holdover();
    int t_hold, t_drop;
    t_hold = -1; t_drop = -1;
    do_reset();
    lock_at(mk(12, 1, 24, 3, 10, 7));
    for (int n = 1; n <= 18105; n++) begin
      tick(1, 0, z);
      if (holdover && t_hold < 0) t_hold = n;
      if (!locked && t_drop < 0) t_drop = n;
    end
    vectors++;
    if (t_hold != 6100) begin
      miscompares++; $display("FAIL holdover_entry: got tick %0d expected 6100", t_hold);
    end
    vectors++;
    if (t_drop != 18100) begin
      miscompares++; $display("FAIL holdover_drop: got tick %0d expected 18100", t_drop);
    end
    vectors++;
    if (act !== exp_out()) begin
      miscompares++; $display("FAIL holdover_model: got %h expected %h", act, exp_out());
    end
  endtask

  task automatic test_coincide();
    do_reset();
    lock_at(mk(12, 1, 24, 3, 10, 7));
    repeat (6099) tick(1, 0, z);
    tick(1, 1, mk(12, 2, 24, 3, 10, 7));
    vectors++;
    if ({dcf77_sync, locked, holdover, sync_minute} !== {3'b110, 8'h02}) begin
      miscompares++; $display("FAIL coincide: got %h expected %h", {dcf77_sync, locked, holdover, sync_minute}, {3'b110, 8'h02});
    end
    repeat (6099) tick(1, 0, z);
    vectors++;
    if ({locked, holdover} !== 2'b10) begin
      miscompares++; $display("FAIL coincide_counter: got %b expected 10", {locked, holdover});
    end
    tick(0, 1, mk(12, 3, 24, 3, 10, 7));
    vectors++;
    if (dcf77_sync !== 1'b1) begin
      miscompares++; $display("FAIL pending_before_reset: got %b expected 1", dcf77_sync);
    end
    do_reset();
    vectors++;
    if ({dcf77_sync, locked} !== 2'b00 || act !== exp_out()) begin
      miscompares++; $display("FAIL reset_abort: got %h expected %h", act, exp_out());
    end
  endtask

  task automatic test_random();
    frm_t prev, f;
    int longs, r;
    longs = 0;
    do_reset();
    prev = rnd_frame();
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 99);
      if (r >= 85 && longs < 3) begin
        longs++;
        for (int i = FT + $urandom_range(0, 200); i > 0; i--) begin
          tick(1, 0, z);
          vectors++;
          if (act !== exp_out()) begin
            miscompares++; $display("FAIL random_gap: got %h expected %h", act, exp_out());
          end
        end
        continue;
      end
      if (r < 70) begin
        f = prev;
        f.mod = (prev.mod + 1) % 1440;
        if (prev.mod == 1439) begin
          f.y = $urandom_range(0, 99); f.mo = $urandom_range(1, 12); f.d = $urandom_range(1, 28); f.w = $urandom_range(1, 7);
        end
      end else f = rnd_frame();
      for (int i = $urandom_range(1, 30); i > 0; i--) begin
        tick(1'($urandom_range(0, 1)), 0, z);
        vectors++;
        if (act !== exp_out()) begin
          miscompares++; $display("FAIL random_idle: got %h expected %h", act, exp_out());
        end
      end
      tick(1'($urandom_range(0, 1)), 1, f);
      vectors++;
      if (act !== exp_out()) begin
        miscompares++; $display("FAIL random_frame: got %h expected %h", act, exp_out());
      end
      prev = f;
    end
  endtask

  initial begin
    z = mk(0, 0, 0, 1, 1, 1);
    model_reset();
    test_reset();
    test_lock();
    test_midnight();
    test_reject();
    test_holdover();
    test_coincide();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dcf77_sync_ctrl.md
DCF77_SYNC_CTRL -- requirements
Module: dcf77_sync_ctrl

Interface
REQ-001 SHALL have parameter REQUIRED_MATCHES, default 2, meaning the number of consecutive plausible frames needed to lock (legal range 2..7).
REQ-002 SHALL have parameter HOLDOVER_MIN, default 60, meaning the number of missed or rejected minutes tolerated before lock is dropped (legal range 1..255).
REQ-003 SHALL have parameter FRAME_TIMEOUT, default 6100, meaning the clk_en ticks without a frame before a minute is counted missed (legal range 6001..8191).
REQ-004 Port: clk  in  1  24 MHz clock; the block uses one clock.
REQ-005 Port: reset_n  in  1  reset, synchronous and active-low.
REQ-006 Port: clk_en  in  1  10 ms tick enable.
REQ-007 Port: frame_valid  in  1  one-cycle pulse meaning a decoded, parity-checked minute frame is on frame_* this cycle.
REQ-008 Ports: frame_year, frame_month, frame_day, frame_hour, frame_minute  in  8 each  two BCD digits, [7:4] tens, [3:0] units.
REQ-009 Port: frame_day_of_week  in  3  1..7.
REQ-010 Port: dcf77_sync  out  1  sync strobe to the free-running clock.
REQ-011 Ports: sync_year, sync_month, sync_day, sync_hour, sync_minute  out  8 each; sync_day_of_week  out  3  accepted time.
REQ-012 Ports: locked  out  1; holdover  out  1  lock status.
REQ-013 Ports: good_frames, rejected_frames  out  16 each  statistics.

Function
REQ-014 States SHALL be UNLOCKED, CANDIDATE, LOCKED and HOLDOVER; locked SHALL be 1 in LOCKED and HOLDOVER, and holdover SHALL be 1 only in HOLDOVER.
REQ-015 A stored reference frame (ref) SHALL be kept; expected = ref plus one minute in BCD, with minute 59->00 carrying into hour, and hour 23->00.
REQ-016 Plausible SHALL mean frame minute/hour == expected, and the date fields and day of week == ref; the date and day-of-week compare SHALL be skipped when ref is 23:59.
REQ-017 Tick counter: 13 bits; SHALL count clk_en pulses; SHALL clear on frame_valid; on reaching FRAME_TIMEOUT SHALL raise a one-cycle timeout and reload to FRAME_TIMEOUT-6000.
REQ-018 UNLOCKED: on frame_valid SHALL load ref=frame, set match_cnt=1 and go to CANDIDATE.
REQ-019 CANDIDATE: a plausible frame SHALL load ref and increment match_cnt; when match_cnt reaches REQUIRED_MATCHES the block SHALL go to LOCKED and issue sync.
REQ-020 CANDIDATE: an implausible frame SHALL load ref and set match_cnt=1; a timeout SHALL go to UNLOCKED.
REQ-021 LOCKED/HOLDOVER: a plausible frame SHALL load ref, clear miss_cnt, go to LOCKED and issue sync.
REQ-022 LOCKED/HOLDOVER: an implausible frame or a timeout SHALL advance ref by one minute, increment miss_cnt, issue no sync and go to HOLDOVER.
REQ-023 HOLDOVER: when miss_cnt reaches HOLDOVER_MIN the block SHALL go to UNLOCKED.
REQ-024 Issuing sync SHALL load sync_* from the frame in the same cycle and set dcf77_sync high from the next cycle through the first subsequent cycle with clk_en=1 inclusive, then low (exactly one clk_en-qualified cycle seen by the clock).
REQ-025 sync_* SHALL be stable whenever dcf77_sync=1.
REQ-026 A new issue while dcf77_sync is pending SHALL overwrite sync_* and keep the strobe pending.
REQ-027 frame_valid and timeout in the same cycle: the frame SHALL be processed and the timeout discarded.
REQ-028 frame_valid coinciding with clk_en: the tick counter SHALL clear (clear wins over increment).

Reset
REQ-029 On reset_n=0 at a clk edge, the block SHALL enter UNLOCKED.
REQ-030 Reset SHALL set dcf77_sync=0, locked=0, holdover=0, match_cnt=0, miss_cnt=0 and tick counter=0.
REQ-031 Reset SHALL set sync_year=00, sync_month=01, sync_day=01, sync_day_of_week=1, sync_hour=00, sync_minute=00, and ref to the same values.
REQ-032 Reset SHALL set good_frames=0 and rejected_frames=0.
REQ-033 Reset SHALL have priority over clk_en and frame_valid, and SHALL abort a pending sync strobe.

Configuration
REQ-034 Macro DCF77_SYNC_STATS_EN defined: good_frames SHALL count plausible frames and rejected_frames SHALL count implausible frames, both saturating at 16'hFFFF.
REQ-035 Macro DCF77_SYNC_STATS_EN undefined: both ports SHALL be constant 0, with no counter logic.

Verification
REQ-036 After reset, frames 12:00 then 12:01 (dates equal), 6000 ticks apart -> locked=1 after the second frame; dcf77_sync is high exactly one clk_en cycle; sync_minute=8'h01.
REQ-037 Locked at 23:59 on 31.12.24, then frame 00:00 on 01.01.25 -> accepted, sync issued, sync_year=8'h25.
REQ-038 Locked, then frame 12:05 when 12:02 is expected -> no sync, holdover=1, rejected_frames=1 (with the macro), and the next frame 12:03 relocks.
REQ-039 Locked with HOLDOVER_MIN=3, no frames -> timeouts at 6100, 12100 and 18100 ticks; locked drops to 0 at the third timeout.
REQ-040 frame_valid in the same cycle as a timeout -> frame processed and miss_cnt unchanged; reset_n=0 during a pending strobe -> dcf77_sync=0 next cycle.
